sobolrng_mdim: RTL and testbench
================================

// Module: sobolrng_mdim
// PURPOSE
// - Multi-dimension Sobol RNG for the stochastic-computing datapath (SFFT scalers, bitstream generators).
// - One shared index counter derives the direction-vector select internally (lowest zero bit of index).
// - NUM_DIM dimensions, each with its own state register and direction vectors.
// - Produces one quasi-random sample per dimension per accepted transfer.
// - Valid/ready output handshake; wrap pulse at end of the 2^BITWIDTH period.
// PARAMETERS
// - BITWIDTH  8  sample width; period = 2^BITWIDTH; direction vectors per dimension = BITWIDTH
// - NUM_DIM   2  number of independent Sobol dimensions sharing the index counter
// PORTS
// - iClk      in   1                           clock
// - iRst      in   1                           reset, synchronous, active-high
// - iEn       in   1                           generator enable; drives oValid one cycle later
// - iClr      in   1                           synchronous clear of index/state/valid
// - iDirVec   in   NUM_DIM*BITWIDTH*BITWIDTH   direction vectors; dim d, vector k at [((d*BITWIDTH+k)*BITWIDTH) +: BITWIDTH]
// - iReady    in   1                           consumer accepts oRand this cycle
// - oValid    out  1                           oRand holds a sample
// - oRand     out  NUM_DIM*BITWIDTH            sample per dim; dim d at [d*BITWIDTH +: BITWIDTH]
// - oIdx      out  BITWIDTH                    sequence index of the current oRand
// - oWrap     out  1                           one-cycle pulse: period completed, index restarted
// BEHAVIOUR
// - Reset (iRst=1 at posedge): oRand=0, oIdx=0, oValid=0, oWrap=0. Priority: iRst > iClr > advance.
// - iClr=1: same values as reset, next edge; iDirVec not sampled.
// - oValid <= iEn every cycle (1-cycle latency, no iClr/iRst present).
// - Fire = oValid & iReady. No fire -> oRand, oIdx held stable (valid-hold rule).
// - On fire with oIdx != all-ones:
//   - k = index of lowest 0 bit of oIdx; one-hot = ~oIdx & (oIdx+1).
//   - For each dim d: oRand[d] <= oRand[d] ^ iDirVec[d][k].
//   - oIdx <= oIdx + 1; oWrap <= 0.
// - On fire with oIdx == all-ones (one-hot is zero):
//   - oRand <= 0 (all dims); oIdx <= 0; oWrap <= 1 for one cycle.
// - oWrap is 0 on every cycle without a wrap fire.
// - oRand is XOR of direction vectors of gray(oIdx) bits, i.e. the Gray-code Sobol order.
// - First sample after reset/clear is index 0, value 0 in every dimension.
// - iEn dropping: oValid falls next cycle; state frozen, resumes where it stopped.
// - iDirVec is sampled only on fire edges; changing it mid-sequence takes effect at the next fire.
// - Select and XOR are fully combinational on oIdx. Registers: oRand, oIdx, oValid, oWrap.
// CONFIGURATION
// - Macro SOBOLRNG_MDIM_SCRAMBLE_EN.
// - Defined: adds input iScramble (NUM_DIM*BITWIDTH).
//   - Output becomes oRand[d] = state[d] ^ iScramble[d] (combinational XOR after the state register).
//   - State advance and wrap behaviour are unchanged.
//   - Reset/clear state = 0, so oRand = iScramble while in reset.
// - Undefined: no iScramble port; oRand = state; reset oRand = 0.
// TESTING (BITWIDTH=4, NUM_DIM=2; dim0 vectors k0..k3 = 8,4,2,1; dim1 = 8,12,10,15; iReady=1 unless stated)
// - Reset then iEn=1: oValid rises 1 cycle after iEn.
//   - dim0 sequence 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1 with oIdx 0..15.
//   - dim1 sequence starts 0,8,4,12.
// - Continue past index 15 (dim0=1): next sample dim0=0, dim1=0, oIdx=0; oWrap=1 for exactly one cycle;
//   sequence repeats 8,12,...
// - Backpressure: iReady=0 for 5 cycles at oIdx=3.
//   - oRand holds dim0=4, oIdx=3 for all 5 cycles.
//   - After iReady=1, next value is 6; no sample skipped or duplicated.
// - Mid-run at oIdx=9: assert iClr with iReady=1 (clear wins over advance) -> next cycle oRand=0, oIdx=0, oValid=0;
//   with iEn=1 oValid returns the following cycle.
// - Mid-run at oIdx=6: assert iRst for 1 cycle -> all outputs 0 at that edge; sequence restarts from 0.
// - SCRAMBLE_EN build, iScramble dim0=4'hF: dim0 outputs 15,7,3,11 for oIdx 0..3; oWrap timing identical to unscrambled build.

Source files
------------

// File: rtl/sobolrng_mdim.sv
// ---------------------------------------------------------------------------
// sobolrng_mdim
//   Multi-dimension Sobol quasi-random generator for the stochastic-computing
//   datapath. Every dimension shares one index counter. The direction vector
//   used on each step is the one selected by the lowest zero bit of the index,
//   which produces the Gray-code Sobol order. Each accepted transfer
//   (oValid & iReady) advances every dimension by one sample. oWrap pulses for
//   one cycle when the 2^BITWIDTH period completes.
//
//   Optional build macro SOBOLRNG_MDIM_SCRAMBLE_EN:
//     When defined, the block adds an iScramble input. Each dimension's output
//     is the state register XORed with its scramble word. The state sequence
//     and the wrap behaviour do not change.
//     When undefined, oRand is the raw state.
// ---------------------------------------------------------------------------
module sobolrng_mdim #(
  parameter int BITWIDTH = 8,
  parameter int NUM_DIM  = 2
) (
  input  logic                                  iClk,
  input  logic                                  iRst,
  input  logic                                  iEn,
  input  logic                                  iClr,
  input  logic [NUM_DIM*BITWIDTH*BITWIDTH-1:0]  iDirVec,
`ifdef SOBOLRNG_MDIM_SCRAMBLE_EN
  input  logic [NUM_DIM*BITWIDTH-1:0]           iScramble,
`endif
  input  logic                                  iReady,
  output logic                                  oValid,
  output logic [NUM_DIM*BITWIDTH-1:0]           oRand,
  output logic [BITWIDTH-1:0]                   oIdx,
  output logic                                  oWrap
);

  localparam logic [BITWIDTH-1:0] IDX_ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};

  // Registered state
  logic [BITWIDTH-1:0]         idx_q,   idx_d;
  logic [NUM_DIM*BITWIDTH-1:0] state_q, state_d;
  logic                        valid_q, valid_d;
  logic                        wrap_q,  wrap_d;

  // Combinational helpers
  logic                        fire;
  logic                        idx_last;
  logic [BITWIDTH-1:0]         sel_onehot;
  logic [NUM_DIM*BITWIDTH-1:0] dir_sel;

  assign fire     = valid_q & iReady;
  assign idx_last = &idx_q;

  // Select each dimension's direction vector from the lowest zero bit of the index
  always_comb begin
    // NOTE: every signal gets a default before any conditional update.
    // This keeps the block free of latches.
    sel_onehot = ~idx_q & (idx_q + IDX_ONE);
    dir_sel    = '0;
    for (int d = 0; d < NUM_DIM; d++) begin
      for (int k = 0; k < BITWIDTH; k++) begin
        dir_sel[d*BITWIDTH +: BITWIDTH] = dir_sel[d*BITWIDTH +: BITWIDTH]
          | (iDirVec[((d*BITWIDTH + k)*BITWIDTH) +: BITWIDTH] & {BITWIDTH{sel_onehot[k]}});
      end
    end
  end

  // Next state: clear wins over advance, and a fire on the last index wraps to zero
  always_comb begin
    idx_d   = idx_q;
    state_d = state_q;
    valid_d = iEn;
    wrap_d  = 1'b0;
    if (iClr) begin
      idx_d   = '0;
      state_d = '0;
      valid_d = 1'b0;
    end else if (fire) begin
      if (idx_last) begin
        idx_d   = '0;
        state_d = '0;
        wrap_d  = 1'b1;
      end else begin
        idx_d   = idx_q + IDX_ONE;
        state_d = state_q ^ dir_sel;
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge iClk) begin
    // NOTE: use non-blocking assignments for every flop.
    // Each register then sees the pre-edge value of the others.
    if (iRst) begin
      idx_q   <= '0;
      state_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      state_q <= state_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign oValid = valid_q;
  assign oIdx   = idx_q;
  assign oWrap  = wrap_q;

`ifdef SOBOLRNG_MDIM_SCRAMBLE_EN
  assign oRand = state_q ^ iScramble;
`else
  assign oRand = state_q;
`endif

endmodule

// File: tb/tb_sobolrng_mdim.sv
// ---------------------------------------------------------------------------
// tb_sobolrng_mdim
//   Scoreboard bench for sobolrng_mdim with BITWIDTH=4 and NUM_DIM=2.
//   Each time a cycle's stimulus is driven, the bench updates its model.
//   The model computes each sample from the Gray code of the index.
//   When the model predicts a fire, the accepted sample is popped and the
//   next expected sample is pushed. After every edge, the DUT outputs are
//   compared against the front of the queue.
//   Covered sequences:
//     - a full period plus the wrap
//     - backpressure
//     - clear and reset mid-run
//     - an enable drop
// ---------------------------------------------------------------------------
module tb_sobolrng_mdim;

  localparam int BW = 4;
  localparam int ND = 2;

  logic                iClk = 1'b0;
  logic                iRst, iEn, iClr, iReady;
  logic [ND*BW*BW-1:0] iDirVec;
  logic                oValid, oWrap;
  logic [ND*BW-1:0]    oRand;
  logic [BW-1:0]       oIdx;
`ifdef SOBOLRNG_MDIM_SCRAMBLE_EN
  logic [ND*BW-1:0]    iScramble = 8'h3F;
`endif

  sobolrng_mdim #(.BITWIDTH(BW), .NUM_DIM(ND)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEn       (iEn),
    .iClr      (iClr),
    .iDirVec   (iDirVec),
`ifdef SOBOLRNG_MDIM_SCRAMBLE_EN
    .iScramble (iScramble),
`endif
    .iReady    (iReady),
    .oValid    (oValid),
    .oRand     (oRand),
    .oIdx      (oIdx),
    .oWrap     (oWrap)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [BW-1:0]    idx;
    logic [ND*BW-1:0] rnd;
  } exp_t;

  logic [BW-1:0] dv [ND][BW];
  exp_t          exp_q[$];
  logic [BW-1:0] mdl_idx;
  logic          exp_valid;
  logic          exp_wrap;
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Gray-code Sobol model: XOR of the direction vectors selected by gray(idx)
  function automatic exp_t sample(input logic [BW-1:0] idx);
    exp_t          e;
    logic [BW-1:0] g;
    g     = idx ^ (idx >> 1);
    e.idx = idx;
    e.rnd = '0;
    for (int d = 0; d < ND; d++)
      for (int j = 0; j < BW; j++)
        if (g[j]) e.rnd[d*BW +: BW] = e.rnd[d*BW +: BW] ^ dv[d][j];
`ifdef SOBOLRNG_MDIM_SCRAMBLE_EN
    e.rnd = e.rnd ^ iScramble;
`endif
    return e;
  endfunction

  // Drive one cycle, update the model, then check the outputs after the edge
  task automatic cycle(input logic en, input logic rdy, input logic clr, input logic rst);
    logic fire_m;
    iEn = en; iReady = rdy; iClr = clr; iRst = rst;
    fire_m = exp_valid & rdy;
    if (rst || clr) begin
      exp_q.delete();
      mdl_idx  = '0;
      exp_q.push_back(sample(mdl_idx));
      exp_wrap = 1'b0;
    end else if (fire_m) begin
      exp_wrap = (mdl_idx == 4'hF);
      void'(exp_q.pop_front());
      mdl_idx  = mdl_idx + 4'd1;
      exp_q.push_back(sample(mdl_idx));
    end else begin
      exp_wrap = 1'b0;
    end
    exp_valid = en & ~clr & ~rst;
    @(posedge iClk);
    #1;
    check("valid", {31'd0, oValid}, {31'd0, exp_valid});
    check("wrap",  {31'd0, oWrap},  {31'd0, exp_wrap});
    check("idx",   {28'd0, oIdx},   {28'd0, exp_q[0].idx});
    check("rand",  {24'd0, oRand},  {24'd0, exp_q[0].rnd});
  endtask

  initial begin
    dv[0][0] = 4'd8; dv[0][1] = 4'd4;  dv[0][2] = 4'd2;  dv[0][3] = 4'd1;
    dv[1][0] = 4'd8; dv[1][1] = 4'd12; dv[1][2] = 4'd10; dv[1][3] = 4'd15;
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < BW; k++)
        iDirVec[((d*BW + k)*BW) +: BW] = dv[d][k];
    iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iReady = 1'b1;
    mdl_idx   = '0;
    exp_valid = 1'b0;
    exp_wrap  = 1'b0;
    exp_q.push_back(sample(mdl_idx));

    // Reset, then one idle cycle with iEn low
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Full period and the wrap, ending at index 3 of the second period
    for (int n = 0; n < 20; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: hold index 3 for five cycles
    for (int n = 0; n < 5; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Run to index 9, then clear while iReady is high
    for (int n = 0; n < 40 && mdl_idx != 4'd9; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Run to index 6, then pulse reset
    for (int n = 0; n < 40 && mdl_idx != 4'd6; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Enable drop: state freezes, then resumes
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
